// File: rtl/delivery_game_pkg.sv
// Shared state codes, timing constants and row-generation helpers for the delivery game.
package delivery_game_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StInit = 4'd1,
    StPlay = 4'd2,
    StEval = 4'd3,
    StGen  = 4'd4,
    StLose = 4'd5,
    StWin  = 4'd6
  } state_e;

  localparam int unsigned MeasPeriod  = 60;
  localparam int unsigned EchoTimeout = 30;
  localparam int unsigned TickFast    = 250;
  localparam int unsigned TickMed     = 500;
  localparam int unsigned TickSlow    = 1000;
  localparam int unsigned PwmPeriod   = 20;
  localparam int unsigned WinScore    = 7;

  localparam int unsigned MeasW = 6;
  localparam int unsigned EchoW = 5;
  localparam int unsigned TickW = 10;
  localparam int unsigned PwmW  = 5;

  localparam logic [7:0] LfsrSeed = 8'hA5;

  function automatic logic [3:0] row_obstacle(input logic [7:0] l);
    return 4'b0001 << l[1:0];
  endfunction

  // An offset of 3 would wrap back onto the obstacle lane; it folds to the adjacent lane.
  function automatic logic [3:0] row_objective(input logic [7:0] l);
    logic [1:0] lane;
    lane = l[1:0] + 2'd1 + ((l[4:3] == 2'd3) ? 2'd0 : l[4:3]);
    return l[2] ? (4'b0001 << lane) : 4'b0000;
  endfunction

endpackage

// File: rtl/delivery_sensor.sv
// Ultrasonic ranging: periodic trigger, synchronized echo-width count, tick-period select.
module delivery_sensor
  import delivery_game_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_echo,
  output logic             o_trigger,
  output logic [TickW-1:0] o_tick_period
);

  logic [MeasW-1:0] r_meas;
  logic             r_trigger;
  logic             r_echo_s1;
  logic             r_echo_s2;
  logic             r_echo_prev;
  logic             r_armed;
  logic             r_valid;
  logic [EchoW-1:0] r_count;
  logic [EchoW-1:0] r_latched;
  logic             w_meas_wrap;
  logic             w_fall;

  assign w_meas_wrap = (r_meas == MeasW'(MeasPeriod - 1));
  assign w_fall      = r_echo_prev & ~r_echo_s2;
  assign o_trigger   = r_trigger;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meas      <= '0;
      r_trigger   <= 1'b0;
      r_echo_s1   <= 1'b0;
      r_echo_s2   <= 1'b0;
      r_echo_prev <= 1'b0;
      r_armed     <= 1'b0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_latched   <= '0;
    end else begin
      r_meas      <= w_meas_wrap ? '0 : r_meas + 1'b1;
      r_trigger   <= w_meas_wrap;
      r_echo_s1   <= i_echo;
      r_echo_s2   <= r_echo_s1;
      r_echo_prev <= r_echo_s2;
      if (r_trigger) begin
        // A measurement still open at the next trigger is closed with whatever it counted.
        if (r_armed) begin
          r_latched <= r_count;
          r_valid   <= 1'b1;
        end
        r_armed <= 1'b1;
        r_count <= '0;
      end else if (r_armed) begin
        if (w_fall) begin
          r_latched <= r_count;
          r_valid   <= 1'b1;
          r_armed   <= 1'b0;
        end else if (r_echo_s2 && (r_count != EchoW'(EchoTimeout))) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_tick_period = TickW'(TickSlow);
    if (r_valid) begin
      if (r_latched <= EchoW'(1)) begin
        o_tick_period = TickW'(TickFast);
      end else if (r_latched == EchoW'(2)) begin
        o_tick_period = TickW'(TickMed);
      end
    end
  end

endmodule

// File: rtl/delivery_game.sv
// Lane-dodging game core: game FSM, player movement, row generation and servo PWM.
module delivery_game
  import delivery_game_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [6:0] botoes,
  input  logic       echo,
  output logic [3:0] estado,
  output logic [2:0] pontuacao,
  output logic       pronto,
  output logic       pwm,
  output logic       trigger,
  output logic [3:0] db_player_position,
  output logic [3:0] db_new_obstacle,
  output logic [3:0] db_new_objective
);

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_pos;
  logic [2:0]       r_score;
  logic [3:0]       r_obst;
  logic [3:0]       r_objv;
  logic [TickW-1:0] r_tick;
  logic [TickW-1:0] r_period;
  logic [TickW-1:0] w_tick_period;
  logic [7:0]       r_lfsr;
  logic [1:0]       r_btn_prev;
  logic [1:0]       w_rise;
  logic [PwmW-1:0]  r_pwm_cnt;
  logic             r_pwm;
  logic             w_move_ok;
  logic [2:0]       w_score_inc;
  logic             w_unused;

  delivery_sensor u_sensor (
    .i_clk         (clock),
    .i_rst_n       (reset),
    .i_echo        (echo),
    .o_trigger     (trigger),
    .o_tick_period (w_tick_period)
  );

  assign w_rise      = botoes[1:0] & ~r_btn_prev;
  assign w_move_ok   = (r_state == StPlay) || (r_state == StEval) || (r_state == StGen);
  assign w_score_inc = r_score + 3'd1;
  assign w_unused    = ^botoes[6:2];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (jogar) w_state_next = StInit;
      StInit: w_state_next = StPlay;
      StPlay: if (r_tick == r_period - 1'b1) w_state_next = StEval;
      StEval: begin
        if (r_obst[r_pos]) begin
          w_state_next = StLose;
        end else if (r_objv[r_pos] && (w_score_inc == 3'(WinScore))) begin
          w_state_next = StWin;
        end else begin
          w_state_next = StGen;
        end
      end
      StGen: w_state_next = StPlay;
      StLose, StWin: if (jogar) w_state_next = StInit;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pos      <= '0;
      r_score    <= '0;
      r_obst     <= '0;
      r_objv     <= '0;
      r_tick     <= '0;
      r_period   <= TickW'(TickSlow);
      r_lfsr     <= LfsrSeed;
      r_btn_prev <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_btn_prev <= botoes[1:0];
      if (w_move_ok) begin
        if ((w_rise == 2'b01) && (r_pos != 2'd0)) begin
          r_pos <= r_pos - 2'd1;
        end else if ((w_rise == 2'b10) && (r_pos != 2'd3)) begin
          r_pos <= r_pos + 2'd1;
        end
      end
      case (r_state)
        StInit: begin
          r_pos    <= '0;
          r_score  <= '0;
          r_obst   <= '0;
          r_objv   <= '0;
          r_tick   <= '0;
          r_period <= w_tick_period;
        end
        StPlay: r_tick <= r_tick + 1'b1;
        StEval: if (!r_obst[r_pos] && r_objv[r_pos]) r_score <= w_score_inc;
        StGen: begin
          r_obst   <= row_obstacle(r_lfsr);
          r_objv   <= row_objective(r_lfsr);
          r_tick   <= '0;
          r_period <= w_tick_period;
        end
        default: ;
      endcase
    end
  end

  // Frame is high for 1+position clocks; output lags the frame counter by one clock.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == PwmW'(PwmPeriod - 1)) ? '0 : r_pwm_cnt + 1'b1;
      r_pwm     <= (r_pwm_cnt <= {3'b000, r_pos});
    end
  end

  assign estado             = r_state;
  assign pontuacao          = r_score;
  assign pronto             = (r_state == StLose) || (r_state == StWin);
  assign pwm                = r_pwm;
  assign db_player_position = {2'b00, r_pos};
  assign db_new_obstacle    = r_obst;
  assign db_new_objective   = r_objv;

endmodule

// File: tb/tb_delivery_game.sv
// Randomized self-checking bench for delivery_game with a game-level reference model.
`timescale 1us/1ns
module tb_delivery_game;

  localparam int ModeDodge   = 0;
  localparam int ModeCollect = 1;
  localparam int ModeIdle    = 2;
  localparam int ModeHit     = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [6:0] botoes = '0;
  logic       echo = 1'b0;
  logic [3:0] estado;
  logic [2:0] pontuacao;
  logic       pronto;
  logic       pwm;
  logic       trigger;
  logic [3:0] db_player_position;
  logic [3:0] db_new_obstacle;
  logic [3:0] db_new_objective;

  delivery_game dut (
    .clock              (clock),
    .reset              (reset),
    .jogar              (jogar),
    .botoes             (botoes),
    .echo               (echo),
    .estado             (estado),
    .pontuacao          (pontuacao),
    .pronto             (pronto),
    .pwm                (pwm),
    .trigger            (trigger),
    .db_player_position (db_player_position),
    .db_new_obstacle    (db_new_obstacle),
    .db_new_objective   (db_new_objective)
  );

  always #500 clock = ~clock;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         echo_len = 3;
  int         m_pos = 0;
  int         m_score = 0;
  int         last_gen = -1;
  int         gen_gap = 0;
  logic [3:0] m_obs = '0;
  logic [3:0] m_objv = '0;
  logic [7:0] m_lfsr = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'b1011_1000)};
  endfunction

  // Returns {objective mask, obstacle mask} for a row drawn from LFSR value s.
  function automatic logic [7:0] row_of(input logic [7:0] s);
    int o;
    int j;
    logic [7:0] r;
    o = int'(s[1:0]);
    j = (o + 1 + int'(s[4:3])) % 4;
    if (j == o) j = (o + 1) % 4;
    r[3:0] = 4'(1 << o);
    r[7:4] = s[2] ? 4'(1 << j) : 4'b0000;
    return r;
  endfunction

  function automatic int lane_of(input logic [3:0] m);
    int l;
    l = 0;
    for (int i = 0; i < 4; i++) if (m[i]) l = i;
    return l;
  endfunction

  function automatic int period_model(input int len);
    int c;
    c = (len > 30) ? 30 : len;
    if (c <= 1) return 250;
    if (c == 2) return 500;
    return 1000;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) m_lfsr <= 8'hA5;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  // Sensor stand-in: answers every trigger with an echo echo_len clocks wide.
  initial forever begin
    @(negedge clock);
    if (trigger === 1'b1 && echo_len > 0) begin
      echo = 1'b1;
      repeat (echo_len) @(negedge clock);
      echo = 1'b0;
    end
  end

  initial begin
    #95_000_000;
    $display("FAIL watchdog: simulation still running at 95000 clocks, required finish");
    $fatal(1);
  end

  task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
    int i;
    i = 0;
    while (estado !== code && i < budget) begin
      @(negedge clock);
      i++;
    end
    ok = (estado === code);
  endtask

  task automatic press(input logic [1:0] dir, input bit live);
    botoes = {5'($urandom), dir};
    @(negedge clock);
    botoes = {5'($urandom), 2'b00};
    @(negedge clock);
    if (live && dir == 2'b01 && m_pos > 0) m_pos--;
    else if (live && dir == 2'b10 && m_pos < 3) m_pos++;
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    n_cmp++;
    if (estado !== 4'd1) begin
      n_fail++;
      $display("FAIL start_init: estado=%0d required=1", estado);
    end
    @(negedge clock);
    m_pos = 0; m_score = 0; last_gen = -1;
    n_cmp++;
    if ({estado, pontuacao, pronto, db_player_position, db_new_obstacle, db_new_objective}
        !== {4'd2, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL start_play: estado=%0d score=%0d pronto=%b pos=%0d obs=%b obj=%b required 2/0/0/0/0000/0000",
               estado, pontuacao, pronto, db_player_position, db_new_obstacle, db_new_objective);
    end
  endtask

  // One game tick from GEN through EVAL; res: 0 continue, 1 lose, 2 win, -1 timeout.
  task automatic play_tick(input int mode, output int res);
    bit ok;
    logic [7:0] row;
    logic [3:0] exp_st;
    int tgt;
    res = -1;
    wait_state(4'd4, 1200, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_gen: estado=%0d required=4 within 1200 clocks", estado);
    end else begin
      if (last_gen >= 0) gen_gap = cyc - last_gen;
      last_gen = cyc;
      row = row_of(m_lfsr);
      m_obs = row[3:0];
      m_objv = row[7:4];
      @(negedge clock);
      n_cmp++;
      if (db_new_obstacle !== m_obs || db_new_objective !== m_objv) begin
        n_fail++;
        $display("FAIL row: obs=%b obj=%b required obs=%b obj=%b",
                 db_new_obstacle, db_new_objective, m_obs, m_objv);
      end
      tgt = m_pos;
      if (mode == ModeHit) begin
        tgt = lane_of(m_obs);
      end else if (mode == ModeCollect && m_objv != 4'b0000) begin
        tgt = lane_of(m_objv);
      end else if (mode != ModeIdle) begin
        tgt = int'($urandom_range(0, 3));
        while (m_obs[tgt] || m_objv[tgt]) tgt = (tgt + 1) % 4;
      end
      while (m_pos != tgt) press((tgt > m_pos) ? 2'b10 : 2'b01, 1'b1);
      n_cmp++;
      if (db_player_position !== 4'(m_pos)) begin
        n_fail++;
        $display("FAIL tick_pos: pos=%0d required=%0d", db_player_position, m_pos);
      end
      wait_state(4'd3, 1100, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL wait_eval: estado=%0d required=3 within 1100 clocks", estado);
      end else begin
        if (m_obs[m_pos]) begin
          exp_st = 4'd5; res = 1;
        end else begin
          if (m_objv[m_pos]) m_score++;
          if (m_score == 7) begin exp_st = 4'd6; res = 2; end
          else begin exp_st = 4'd4; res = 0; end
        end
        @(negedge clock);
        n_cmp++;
        if (estado !== exp_st || pontuacao !== 3'(m_score) || pronto !== (res != 0)) begin
          n_fail++;
          $display("FAIL eval: estado=%0d score=%0d pronto=%b required %0d/%0d/%b",
                   estado, pontuacao, pronto, exp_st, m_score, (res != 0));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({estado, pontuacao, pronto, pwm, trigger, db_player_position, db_new_obstacle,
         db_new_objective} !== '0) begin
      n_fail++;
      $display("FAIL reset: estado=%0d score=%0d pronto=%b pwm=%b trig=%b pos=%0d obs=%b obj=%b required all 0",
               estado, pontuacao, pronto, pwm, trigger, db_player_position, db_new_obstacle,
               db_new_objective);
    end
    reset = 1'b1;
    m_pos = 0; m_score = 0; last_gen = -1;
    press(2'b10, 1'b0);
    n_cmp++;
    if (estado !== 4'd0 || db_player_position !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_move: estado=%0d pos=%0d required 0/0", estado, db_player_position);
    end
  endtask

  task automatic test_trigger();
    int cnt;
    cnt = 0;
    while (trigger !== 1'b1 && cnt < 70) begin @(negedge clock); cnt++; end
    n_cmp++;
    if (trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_seen: trigger=%b required=1 within 70 clocks", trigger);
    end
    @(negedge clock);
    n_cmp++;
    if (trigger !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_width: trigger=%b required=0", trigger);
    end
    cnt = 1;
    while (trigger !== 1'b1 && cnt < 70) begin @(negedge clock); cnt++; end
    n_cmp++;
    if (cnt != 60) begin
      n_fail++;
      $display("FAIL trig_period: period=%0d required=60", cnt);
    end
  endtask

  task automatic test_movement();
    int exp_r [4] = '{1, 2, 3, 3};
    int exp_l [4] = '{2, 1, 0, 0};
    logic [1:0] dirs [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    int hi;
    start_game();
    for (int i = 0; i < 4; i++) begin
      press(2'b10, 1'b1);
      n_cmp++;
      if (db_player_position !== 4'(exp_r[i])) begin
        n_fail++;
        $display("FAIL move_right%0d: pos=%0d required=%0d", i, db_player_position, exp_r[i]);
      end
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      @(negedge clock);
      for (int i = 0; i < 20; i++) begin @(negedge clock); hi += int'(pwm); end
      n_cmp++;
      if (hi != m_pos + 1) begin
        n_fail++;
        $display("FAIL pwm_width: high=%0d required=%0d", hi, m_pos + 1);
      end
      if (p == 0) begin
        for (int i = 0; i < 4; i++) begin
          press(2'b01, 1'b1);
          n_cmp++;
          if (db_player_position !== 4'(exp_l[i])) begin
            n_fail++;
            $display("FAIL move_left%0d: pos=%0d required=%0d", i, db_player_position, exp_l[i]);
          end
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      press(dirs[$urandom_range(0, 3)], 1'b1);
      n_cmp++;
      if (db_player_position !== 4'(m_pos)) begin
        n_fail++;
        $display("FAIL move_rand%0d: pos=%0d required=%0d", i, db_player_position, m_pos);
      end
    end
  endtask

  task automatic test_period();
    int lens [4];
    int res;
    lens = '{1, 2, int'($urandom_range(3, 28)), int'($urandom_range(31, 50))};
    for (int k = 0; k < 4; k++) begin
      echo_len = lens[k];
      for (int t = 0; t < 3; t++) play_tick(ModeDodge, res);
      n_cmp++;
      if (gen_gap != period_model(lens[k]) + 2) begin
        n_fail++;
        $display("FAIL tick_gap echo=%0d: gap=%0d required=%0d",
                 lens[k], gen_gap, period_model(lens[k]) + 2);
      end
    end
  endtask

  task automatic test_lose();
    int res;
    echo_len = 1;
    play_tick(ModeHit, res);
    press(2'b10, 1'b0);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (estado !== 4'd5 || pronto !== 1'b1 || pontuacao !== 3'(m_score) ||
        db_player_position !== 4'(m_pos)) begin
      n_fail++;
      $display("FAIL lose_hold: estado=%0d pronto=%b score=%0d pos=%0d required 5/1/%0d/%0d",
               estado, pronto, pontuacao, db_player_position, m_score, m_pos);
    end
    start_game();
  endtask

  task automatic test_win();
    int res;
    res = 0;
    for (int t = 0; t < 60 && res == 0; t++) play_tick(ModeCollect, res);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (estado !== 4'd6 || pronto !== 1'b1 || pontuacao !== 3'd7) begin
      n_fail++;
      $display("FAIL win_hold: estado=%0d pronto=%b score=%0d required 6/1/7",
               estado, pronto, pontuacao);
    end
  endtask

  task automatic test_midgame_reset();
    int res;
    start_game();
    for (int t = 0; t < 2; t++) play_tick(ModeCollect, res);
    repeat (int'($urandom_range(5, 100))) @(negedge clock);
    test_reset();
  endtask

  task automatic test_idle_run();
    int res;
    echo_len = 3;
    start_game();
    res = 0;
    for (int t = 0; t < 30 && res == 0; t++) play_tick(ModeIdle, res);
    n_cmp++;
    if (pronto !== (res > 0)) begin
      n_fail++;
      $display("FAIL idle_run: pronto=%b required=%b", pronto, (res > 0));
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_trigger();
    test_movement();
    test_period();
    test_lose();
    test_win();
    test_midgame_reset();
    test_idle_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
